// File: rtl/snes_pad_poller_if.sv
// SNES controller port pins: latch and clock driven by the poller,
// serial data returned by the pad.
interface snes_pad_poller_if;
  logic pad_latch;
  logic pad_clk;
  logic pad_data;

  modport master (
    output pad_latch,
    output pad_clk,
    input  pad_data
  );

  modport slave (
    input  pad_latch,
    input  pad_clk,
    output pad_data
  );
endinterface

// File: rtl/snes_pad_poller.sv
// SNES pad poller: latches and clocks the pad, shifts in a 16-bit frame
// and reduces it to a button mask plus a priority key code.
module snes_pad_poller #(
  parameter int HALF_CYCLES = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  snes_pad_poller_if.master pad,
  output logic [11:0]       o_buttons,
  output logic [7:0]        o_key_code,
  output logic              o_key_valid,
  output logic              o_pad_present,
  output logic              o_busy
);

  if (HALF_CYCLES < 4) begin : g_bad_half
    $error("HALF_CYCLES must be >= 4");
  end
  if (POLL_CYCLES < 36 * HALF_CYCLES) begin : g_bad_poll
    $error("POLL_CYCLES must be >= 36*HALF_CYCLES");
  end

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int CW = $clog2(2 * HALF_CYCLES);

  localparam logic [PW-1:0] POLL_LOAD  = PW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_LOW,
    S_CLK_HIGH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]    r_sync;
  logic [PW-1:0] r_poll;
  logic [PW-1:0] w_poll;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic [3:0]    r_bit;
  logic [3:0]    w_bit;
  logic [15:0]   r_shift;
  logic [15:0]   w_shift;

  logic r_latch;
  logic r_pclk;
  logic r_busy;
  logic w_latch;
  logic w_pclk;
  logic w_busy;

  logic [11:0] r_buttons;
  logic [7:0]  r_key;
  logic        r_kv;
  logic        r_present;

  logic        w_present;
  logic [11:0] w_buttons;
  logic [7:0]  w_key;
  logic        w_sample;

  // Bits are stored inverted so that 1 means pressed.
  assign w_sample = ~r_sync[1];

  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt + 1'b1;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_poll  = (r_poll != '0) ? r_poll - 1'b1 : r_poll;
    unique case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (i_enable && (r_poll == '0)) begin
          w_next  = S_LATCH;
          w_poll  = POLL_LOAD;
          w_shift = '0;
        end
      end
      S_LATCH: begin
        if (r_cnt == LATCH_LAST) begin
          w_shift[0] = w_sample;
          w_next     = S_CLK_LOW;
          w_cnt      = '0;
          w_bit      = '0;
        end
      end
      S_CLK_LOW: begin
        if (r_cnt == HALF_LAST) begin
          w_next = S_CLK_HIGH;
          w_cnt  = '0;
        end
      end
      S_CLK_HIGH: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt = '0;
          // The 16th pulse carries no data bit.
          if (r_bit == 4'd15) begin
            w_next = S_DONE;
          end else begin
            w_shift[r_bit + 4'd1] = w_sample;
            w_bit  = r_bit + 4'd1;
            w_next = S_CLK_LOW;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
        w_cnt  = '0;
      end
      default: begin
        w_next = S_IDLE;
        w_cnt  = '0;
      end
    endcase
    w_latch = (w_next == S_LATCH);
    w_pclk  = (w_next != S_CLK_LOW);
    w_busy  = (w_next != S_IDLE);
  end

  always_comb begin
    w_present = (r_shift[15:12] == 4'h0);
    w_buttons = w_present ? r_shift[11:0] : 12'h000;
    w_key     = 8'h00;
    for (int i = 11; i >= 0; i--) begin
      if (w_buttons[i]) begin
        w_key = 8'(i + 1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_sync    <= 2'b11;
      r_poll    <= '0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_latch   <= 1'b0;
      r_pclk    <= 1'b1;
      r_busy    <= 1'b0;
      r_buttons <= '0;
      r_key     <= '0;
      r_kv      <= 1'b0;
      r_present <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[0], pad.pad_data};
      r_poll  <= w_poll;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_latch <= w_latch;
      r_pclk  <= w_pclk;
      r_busy  <= w_busy;
      r_kv    <= 1'b0;
      if (r_state == S_DONE) begin
        r_present <= w_present;
        r_buttons <= w_buttons;
        r_key     <= w_key;
        r_kv      <= (w_key != r_key);
      end
    end
  end

  assign pad.pad_latch  = r_latch;
  assign pad.pad_clk    = r_pclk;
  assign o_busy         = r_busy;
  assign o_buttons      = r_buttons;
  assign o_key_code     = r_key;
  assign o_key_valid    = r_kv;
  assign o_pad_present  = r_present;

endmodule

// File: tb/tb_snes_pad_poller.sv
// Randomized bench for snes_pad_poller against a frame-level
// reference model with a shift-on-rising-clock pad.
module tb_snes_pad_poller;
  localparam int H    = 4;
  localparam int P    = 400;
  localparam int FLEN = 34 * H + 1;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;

  logic [11:0] buttons;
  logic [7:0]  key_code;
  logic        key_valid;
  logic        pad_present;
  logic        busy;

  snes_pad_poller_if pif();

  snes_pad_poller #(
    .HALF_CYCLES(H),
    .POLL_CYCLES(P)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_enable     (enable),
    .pad          (pif.master),
    .o_buttons    (buttons),
    .o_key_code   (key_code),
    .o_key_valid  (key_valid),
    .o_pad_present(pad_present),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  logic [15:0] pad_frame = 16'hFFFF;
  logic [15:0] pad_sh    = 16'hFFFF;
  bit          pad_stuck = 1'b0;

  always @(posedge pif.pad_latch) pad_sh = pad_frame;
  always @(posedge pif.pad_clk)
    if (!pif.pad_latch) pad_sh = {1'b1, pad_sh[15:1]};
  assign pif.pad_data = pad_stuck ? 1'b0 : pad_sh[0];

  int prev_key   = 0;
  int last_start = -1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [15:0] raw, input bit stk,
                                output logic [11:0] b,
                                output logic [7:0] k, output bit p);
    logic [15:0] f;
    f = stk ? 16'h0000 : raw;
    p = (f[15:12] == 4'hF);
    b = p ? ~f[11:0] : 12'h000;
    k = 8'h00;
    for (int i = 0; i < 12; i++)
      if (b[i] && k == 8'h00) k = 8'(i + 1);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_latch"},   32'(pif.pad_latch), 32'd0);
    check({tag, "_pclk"},    32'(pif.pad_clk),   32'd1);
    check({tag, "_busy"},    32'(busy),          32'd0);
    check({tag, "_buttons"}, 32'(buttons),       32'd0);
    check({tag, "_key"},     32'(key_code),      32'd0);
    check({tag, "_kv"},      32'(key_valid),     32'd0);
    check({tag, "_present"}, 32'(pad_present),   32'd0);
  endtask

  task automatic do_frame(input logic [15:0] raw, input bit stk,
                          input int drop_p, input int rst_p,
                          input bit chk_sp);
    logic [11:0] eb;
    logic [7:0]  ek;
    bit          ep;
    bit          pc;
    int t, lat, lowc, pulses, busyc, kvc;
    pad_frame = raw;
    pad_stuck = stk;
    model(raw, stk, eb, ek, ep);
    t = 0;
    while (!pif.pad_latch && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("frame_start", 32'(t < 2000), 32'd1);
    if (t >= 2000) return;
    if (chk_sp) check("spacing", 32'(cyc - last_start), 32'(P));
    last_start = cyc;
    lat = 0; lowc = 0; pulses = 0; busyc = 0; kvc = 0; pc = 1'b1;
    while (busy && busyc < 1000) begin
      if (pif.pad_latch) lat++;
      if (!pif.pad_clk) begin
        lowc++;
        if (pc) begin
          pulses++;
          if (pulses == drop_p) enable = 1'b0;
          if (pulses == rst_p) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_reset_vals("midrst");
            prev_key = 0;
            return;
          end
        end
      end
      pc = pif.pad_clk;
      if (key_valid) kvc++;
      busyc++;
      @(negedge clk);
    end
    if (key_valid) kvc++;
    check("latch_len",  32'(lat),    32'(2 * H));
    check("pulses",     32'(pulses), 32'd16);
    check("low_cycles", 32'(lowc),   32'(16 * H));
    check("busy_len",   32'(busyc),  32'(FLEN));
    check("buttons",    32'(buttons),     32'(eb));
    check("key_code",   32'(key_code),    32'(ek));
    check("present",    32'(pad_present), 32'(ep));
    check("kv_count",   32'(kvc), 32'(int'(ek) != prev_key));
    prev_key = int'(ek);
  endtask

  task automatic quiet_window(input string tag, input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pif.pad_latch || !pif.pad_clk || busy) act++;
    end
    check(tag, 32'(act), 32'd0);
  endtask

  initial begin
    logic [15:0] raw, last_raw;
    bit stk;
    int r;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_vals("reset");
    quiet_window("idle_quiet", 500);

    enable = 1'b1;
    do_frame(16'hFFEF, 1'b0, 0, 0, 1'b0);
    do_frame(16'hFEBF, 1'b0, 0, 0, 1'b1);
    do_frame(16'hFEBF, 1'b0, 0, 0, 1'b1);
    do_frame(16'hFFFF, 1'b0, 0, 0, 1'b1);
    do_frame(16'hFFFF, 1'b1, 0, 0, 1'b1);
    do_frame(16'hFFEF, 1'b0, 0, 0, 1'b1);
    do_frame(16'hFFEF, 1'b1, 0, 0, 1'b1);

    do_frame(16'hFF7E, 1'b0, 5, 0, 1'b1);
    quiet_window("disabled_quiet", 500);
    enable = 1'b1;
    do_frame(16'hFFFD, 1'b0, 0, 0, 1'b0);
    do_frame(16'hFBFF, 1'b0, 5, 0, 1'b1);
    enable = 1'b1;
    do_frame(16'hF7FF, 1'b0, 0, 0, 1'b1);

    last_raw = 16'hFFFF;
    for (int n = 0; n < 20; n++) begin
      r   = int'($urandom_range(0, 9));
      stk = 1'b0;
      if (r < 6)       raw = {4'hF, ~12'($urandom & $urandom)};
      else if (r == 6) raw = 16'hFFFF;
      else if (r == 7) raw = 16'($urandom);
      else if (r == 8) begin raw = 16'hFFFF; stk = 1'b1; end
      else             raw = last_raw;
      do_frame(raw, stk, 0, 0, 1'b1);
      last_raw = raw;
    end

    do_frame(16'hFFEF, 1'b0, 0, 0, 1'b1);
    do_frame(16'hFFEF, 1'b0, 0, 8, 1'b1);
    do_frame(16'hFFEF, 1'b0, 0, 0, 1'b0);
    do_frame(16'hFFEF, 1'b0, 0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snes_pad_poller.md
Name: snes_pad_poller

Overview:
Sequences the serial SNES controller interface and generates pad_latch and pad_clk. It shifts in the 16-bit button frame and reduces it to the 8-bit key code that the keyboard/button decoder consumes. It strobes key_valid whenever the code changes; key_valid drives the decoder's latch input. It sits between the controller port pins and the decoder/mux path.

Parameters:
HALF_CYCLES, 300, clk cycles per half-period of pad_clk and per half of the latch pulse (6 us at 50 MHz); must be >= 4.
POLL_CYCLES, 833333, clk cycles between frame starts (60 Hz at 50 MHz); must be >= 36*HALF_CYCLES.

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
enable  input  1  polling enable
pad_data  input  1  serial data from pad, asynchronous, active-low (0 = pressed)
pad_latch  output  1  latch pulse to pad, active-high
pad_clk  output  1  serial clock to pad, idles high
buttons  output  12  pressed mask, 1 = pressed; bit order B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R (bit0 = B)
key_code  output  8  priority-encoded code of lowest-index pressed button (bit i -> i+1), 0 = none
key_valid  output  1  one-cycle strobe when key_code changes
pad_present  output  1  last frame had valid trailer
busy  output  1  frame in progress

Behaviour:
- Reset (synchronous, wins over everything, including mid-frame): state IDLE, pad_latch=0, pad_clk=1, buttons=0, key_code=0, key_valid=0, pad_present=0, busy=0, poll counter=0, shift register=0.
- pad_data passes through a 2-flop synchronizer. All sampling below uses the synchronized value.
- Poll counter: in IDLE with enable=1 and counter==0, the next state is LATCH and the counter loads POLL_CYCLES-1. From then on it decrements every cycle to 0 and holds there. Frame starts are spaced exactly POLL_CYCLES apart while enable stays high.
- enable=0 in IDLE: no frame starts and the counter keeps decrementing to 0. Deasserting enable mid-frame does not abort the frame; the frame completes normally.
- States and transitions:
  - IDLE: pad_latch=0, pad_clk=1, busy=0.
  - LATCH: pad_latch=1 for 2*HALF_CYCLES cycles. On the last cycle, sample bit 0 (B).
  - CLK_LOW: pad_clk=0 for HALF_CYCLES cycles.
  - CLK_HIGH: pad_clk=1 for HALF_CYCLES cycles. On the last cycle of pulse n (n=1..15), sample bit n.
  - Bit count: CLK_LOW -> CLK_HIGH repeats for 16 pulses. Pulse 16 samples nothing.
  - DONE: 1 cycle, then IDLE.
- busy=1 in every state except IDLE.
- Frame length: 2*HALF + 32*HALF + 1 cycles.
- Sampled bits are inverted into the shift register (pressed = 1).
- DONE updates outputs, registered (visible the cycle after DONE):
  - Valid trailer (bits 12..15 all unpressed, raw 1): pad_present=1, buttons=frame[11:0], key_code=index of lowest set bit +1 (0 if none).
  - Bad trailer (pad absent or bus stuck low): pad_present=0, buttons=0, key_code=0.
  - key_valid=1 for exactly that cycle if the new key_code differs from the previous key_code. Otherwise key_valid stays 0.
- key_code is 8 bits wide with values 0..12 only. Codes 1,2,5,6,7,8,9,10 match the decoder's B,Y,UP,DOWN,LEFT,RIGHT,A,X.
- No glitches: pad_latch, pad_clk and key_valid are driven straight from flops.

Test Plan:
(Use HALF_CYCLES=4, POLL_CYCLES=400, and a pad model that shifts on the pad_clk rising edge.)
1. Reset held 3 cycles, then released with enable=0 -> pad_latch=0, pad_clk=1, buttons=0, key_code=0, key_valid=0, pad_present=0, busy=0; no pad activity for 500 cycles.
2. enable=1, pad reports Up only (raw frame 16'hFFEF) -> latch high 8 cycles; 16 low pulses of 4 cycles each; buttons=12'h010, key_code=8'h05, one key_valid pulse, pad_present=1; next frame starts exactly 400 cycles after the first.
3. Left+A pressed (buttons 12'h140) -> key_code=8'h07. Next frame identical -> no key_valid. Then all released -> key_code=0 with one key_valid pulse.
4. pad_data stuck 0 -> pad_present=0, buttons=0, key_code=0; key_valid pulses only if the previous code was nonzero.
5. enable dropped during pulse 5 -> frame completes and outputs update; no new frame starts. Re-enable -> frame starts once the counter reaches 0.
6. reset asserted during pulse 8 -> next cycle all outputs at reset values, pad_clk=1; the previous code is discarded.
